// File: rtl/sseg_scanner_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scanner.
// Segment and anode drives are active-low, so "off" means all ones.
package sseg_scanner_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SLOT_W = 2;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;

  typedef logic [7:0] seg_t;

  // One anode low for the selected slot, all others high.
  function automatic logic [3:0] anodeFor(input logic [SLOT_W-1:0] slot);
    return ~(4'b0001 << slot);
  endfunction

endpackage

// File: rtl/sseg_scanner_tick_gen.sv
// Free-running modulo-DIV counter with a terminal-count pulse.
// The scanner uses one instance for digit slots and one for the blink rate.
module tick_gen #(
  parameter int DIV = 2,
  parameter int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  output logic         tick_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    tick_o = (cnt_q == W'(DIV - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    cnt_o  = cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sseg_scanner.sv
// Time-multiplexed common-anode display driver with dead time, blanking,
// blink and a double buffer that only commits at the start of a frame.
module sseg_scanner
  import sseg_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 5,
  parameter int DEAD_CYCLES = 1,
  parameter int BLINK_DIV = 1250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] digit0,
  input  logic [7:0] digit1,
  input  logic [7:0] digit2,
  input  logic [7:0] digit3,
  input  logic       update,
  input  logic [3:0] blank_mask,
  input  logic [3:0] blink_en,
  output logic       frame,
  output logic [3:0] an,
  output logic [7:0] sseg
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [RW-1:0]     slotCnt;
  logic              slotTick;
  logic              blinkTick;
  logic [BW-1:0]     unusedBlinkCnt;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              blinkOn_q, blinkOn_d;
  logic              pendValid_q, pendValid_d;
  seg_t              act_q [NUM_DIGITS];
  seg_t              act_d [NUM_DIGITS];
  seg_t              pend_q [NUM_DIGITS];
  seg_t              pend_d [NUM_DIGITS];

  logic              boundary;
  logic              dead;
  logic              suppressed;
  logic [3:0]        an_d;
  logic [7:0]        sseg_d;

  tick_gen #(.DIV(REFRESH_DIV)) refreshGen (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (slotTick),
    .cnt_o  (slotCnt)
  );

  tick_gen #(.DIV(BLINK_DIV)) blinkGen (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (blinkTick),
    .cnt_o  (unusedBlinkCnt)
  );

  always_comb begin
    boundary   = (slot_q == '0) && (slotCnt == '0);
    dead       = (slotCnt < RW'(DEAD_CYCLES));
    suppressed = blank_mask[slot_q] | (blink_en[slot_q] & ~blinkOn_q);

    slot_d    = slotTick ? slot_q + 1'b1 : slot_q;
    blinkOn_d = blinkTick ? ~blinkOn_q : blinkOn_q;

    // Commit reads the old pending contents, so a capture on the boundary
    // cycle itself waits for the following frame.
    act_d       = act_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    if (boundary && pendValid_q) begin
      act_d       = pend_q;
      pendValid_d = 1'b0;
    end
    if (update) begin
      pend_d[0]   = digit0;
      pend_d[1]   = digit1;
      pend_d[2]   = digit2;
      pend_d[3]   = digit3;
      pendValid_d = 1'b1;
    end

    an_d   = (dead || suppressed) ? AN_OFF : anodeFor(slot_q);
    sseg_d = suppressed ? SEG_OFF : act_q[slot_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q      <= '0;
      blinkOn_q   <= 1'b1;
      pendValid_q <= 1'b0;
      act_q       <= '{default: SEG_OFF};
      pend_q      <= '{default: SEG_OFF};
      an          <= AN_OFF;
      sseg        <= SEG_OFF;
      frame       <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      blinkOn_q   <= blinkOn_d;
      pendValid_q <= pendValid_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      an          <= an_d;
      sseg        <= sseg_d;
      frame       <= boundary;
    end
  end

endmodule

// File: tb/tb_sseg_scanner.sv
// Directed bench for sseg_scanner with REFRESH_DIV=4, DEAD_CYCLES=1, BLINK_DIV=32,
// so one frame is 16 cycles and the blink phase flips every 32 cycles.
module tb_sseg_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] digit0, digit1, digit2, digit3;
  logic       update;
  logic [3:0] blank_mask, blink_en;
  logic       frame;
  logic [3:0] an;
  logic [7:0] sseg;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sseg_scanner #(
    .REFRESH_DIV(4),
    .DEAD_CYCLES(1),
    .BLINK_DIV(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .update     (update),
    .blank_mask (blank_mask),
    .blink_en   (blink_en),
    .frame      (frame),
    .an         (an),
    .sseg       (sseg)
  );

  // At most one anode may ever be driven low.
  always @(negedge clk) begin
    checks++;
    assert ($countones(~an) <= 1) else begin
      failures++;
      $error("[TB] FAIL anOneHot observed=%h expected=one-hot-low-or-F", an);
    end
  end

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h cyc=%0d", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input logic u);
    {digit3, digit2, digit1, digit0} = d;
    update = u;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Display expected dark; frame pulses when the reflected state is a boundary.
  task automatic checkDark(input int count);
    logic expF;
    for (int i = 0; i < count; i++) begin
      tick();
      expF = (((cyc - 1) % 16) == 0);
      checkOutput("darkSseg", sseg, 8'hFF);
      checkOutput("darkFrame", {7'b0, frame}, {7'b0, expF});
    end
  endtask

  // Checks one whole frame starting at a boundary state; pat is {d3,d2,d1,d0}
  // and dead0 is what slot 0's dead cycle shows (the pre-commit pattern).
  task automatic checkFrame(input logic [31:0] pat, input logic [7:0] dead0,
                            input logic [3:0] bm, input logic [3:0] be,
                            input int ua, input logic [31:0] da,
                            input int ub, input logic [31:0] db);
    logic [3:0] anTbl [4];
    logic [3:0] expAn;
    logic [7:0] expSeg;
    logic       sup;
    int n, slot, cnt;
    anTbl = '{4'hE, 4'hD, 4'hB, 4'h7};
    blank_mask = bm;
    blink_en = be;
    for (int i = 0; i < 16; i++) begin
      if (i == ua) applyStimulus(da, 1'b1);
      else if (i == ub) applyStimulus(db, 1'b1);
      else update = 1'b0;
      tick();
      n = cyc - 1;
      slot = i / 4;
      cnt = i % 4;
      sup = bm[slot] | (be[slot] & (((n / 32) % 2) == 1));
      expSeg = sup ? 8'hFF : ((cnt == 0 && slot == 0) ? dead0 : pat[slot*8 +: 8]);
      expAn = (sup || cnt == 0) ? 4'hF : anTbl[slot];
      checkOutput($sformatf("an s%0d c%0d", slot, cnt), {4'b0, an}, {4'b0, expAn});
      checkOutput($sformatf("sseg s%0d c%0d", slot, cnt), sseg, expSeg);
      checkOutput($sformatf("frame s%0d c%0d", slot, cnt), {7'b0, frame}, {7'b0, (i == 0)});
    end
    update = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(32'h0, 1'b0);
    blank_mask = 4'h0;
    blink_en = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("rstAn", {4'b0, an}, 8'h0F);
    checkOutput("rstSseg", sseg, 8'hFF);
    checkOutput("rstFrame", {7'b0, frame}, 8'h00);
    rst = 1'b0;
    cyc = 0;

    // Empty buffers: dark display, frame every 16 cycles from cycle 1.
    checkDark(32);

    // Mid-frame capture shows from the next frame.
    checkDark(2);
    applyStimulus(32'hB0A4F9C0, 1'b1);
    checkDark(1);
    update = 1'b0;
    checkDark(13);
    checkFrame(32'hB0A4F9C0, 8'hFF, 4'h0, 4'h0, -1, 32'h0, -1, 32'h0);

    // Capture on the boundary cycle waits a full frame.
    checkFrame(32'hB0A4F9C0, 8'hC0, 4'h0, 4'h0, 0, 32'h92929292, -1, 32'h0);
    checkFrame(32'h92929292, 8'hC0, 4'h0, 4'h0, -1, 32'h0, -1, 32'h0);

    // Slot 2 blanked; two captures in one frame, the later one wins.
    checkFrame(32'h92929292, 8'h92, 4'b0100, 4'h0, 3, 32'h44332211, 10, 32'h88776655);

    // Digit 0 blinking: off phase, then on phase.
    checkFrame(32'h88776655, 8'h92, 4'h0, 4'b0001, -1, 32'h0, -1, 32'h0);
    checkFrame(32'h88776655, 8'h55, 4'h0, 4'b0001, -1, 32'h0, -1, 32'h0);
    blink_en = 4'h0;

    // Reset in slot 2 with a capture still pending.
    applyStimulus(32'h12345678, 1'b1);
    tick();
    update = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    checkOutput("midRstAn", {4'b0, an}, 8'h0F);
    checkOutput("midRstSseg", sseg, 8'hFF);
    checkOutput("midRstFrame", {7'b0, frame}, 8'h00);
    tick();
    rst = 1'b0;
    cyc = 0;
    checkDark(20);
    applyStimulus(32'hB0A4F9C0, 1'b1);
    checkDark(1);
    update = 1'b0;
    checkDark(11);
    checkFrame(32'hB0A4F9C0, 8'hFF, 4'h0, 4'h0, -1, 32'h0, -1, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
